// File: rtl/alu_sched_pkg.sv
// Shared types for the ALU round-robin scheduler: FSM state encoding,
// the opcode type and the opcode width.
package alu_sched_pkg;

  localparam int OP_W = 3;

  typedef logic [OP_W-1:0] alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_t;

endpackage

// File: rtl/alu_rr_scheduler_rr_arbiter.sv
// Purely combinational round-robin arbiter. It grants the first requester
// at or after the pointer, searching cyclically. The pointer is owned by
// the caller, so priority only rotates when the caller decides it should.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  int   idx;
  logic found;

  // Walk N positions starting at ptr; the first asserted request wins a one-hot grant
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!found && req[idx[PTR_W-1:0]]) begin
        gnt[idx[PTR_W-1:0]] = 1'b1;
        found               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one external combinational ALU between NUM_REQ requesters.
// One operation is in flight at a time: accept in IDLE, drive the ALU for
// one cycle in EXEC, then hold the tagged result in RESP until consumed.
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 8,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output alu_op_t                   alu_op,
  input  logic [DATA_W-1:0]         alu_o,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy,
  output logic [15:0]               op_count
);

  sched_state_t         state;
  logic [ID_W-1:0]      ptr;
  logic [NUM_REQ-1:0]   grant;
  logic                 accept;
  logic [DATA_W-1:0]    sel_a;
  logic [DATA_W-1:0]    sel_b;
  alu_op_t              sel_op;
  logic [ID_W-1:0]      sel_id;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (ID_W)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (grant)
  );

  // Grants are only offered while idle and out of reset, so a request can
  // never complete a handshake while an operation is already in flight.
  assign req_ready = (reset_n && (state == IDLE)) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign busy      = (state != IDLE);

  // Route the granted requester's operands, opcode and index through a one-hot mux
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    sel_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a  = req_a[i*DATA_W +: DATA_W];
        sel_b  = req_b[i*DATA_W +: DATA_W];
        sel_op = req_op[i*OP_W +: OP_W];
        sel_id = ID_W'(i);
      end
    end
  end

  // Scheduler FSM with the operand, result and pointer registers it owns
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a  <= sel_a;
            alu_b  <= sel_b;
            alu_op <= sel_op;
            rsp_id <= sel_id;
            ptr    <= (sel_id == ID_W'(NUM_REQ - 1)) ? '0 : sel_id + 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= alu_o;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Count every consumed response; the counter wraps naturally at 16 bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_count <= '0;
    end else if (rsp_valid && rsp_ready) begin
      op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Testbench for alu_rr_scheduler. The stimulus side predicts grants with a
// round-robin model and pushes the expected tagged result into a queue; an
// independent monitor checks every presented response against that queue.
module tb_alu_rr_scheduler;
  import alu_sched_pkg::*;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [N*3-1:0]   req_op;
  logic [W-1:0]     alu_a;
  logic [W-1:0]     alu_b;
  alu_op_t          alu_op;
  logic [W-1:0]     alu_o;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IDW-1:0]   rsp_id;
  logic [W-1:0]     rsp_data;
  logic             busy;
  logic [15:0]      op_count;

  typedef struct {
    logic [IDW-1:0] id;
    logic [W-1:0]   data;
    int             due;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks   = 0;
  int          n_fail     = 0;
  int          cyc        = 0;
  int          accepted   = 0;
  int          completed  = 0;
  int          idle_cycle = 0;
  int          model_ptr  = 0;
  logic [15:0] count_base = '0;
  bit          front_seen = 1'b0;

  alu_rr_scheduler #(
    .NUM_REQ (N),
    .DATA_W  (W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_o     (alu_o),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .op_count  (op_count)
  );

  // Reference ALU: add, sub, and, or, xor, not a, shift left, shift right
  function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] op);
    logic [W-1:0] r;
    case (op)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      3'd5:    r = ~a;
      3'd6:    r = a << 1;
      default: r = a >> 1;
    endcase
    return r;
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter used for latency bookkeeping
  always @(posedge clk) cyc <= cyc + 1;

  // The external ALU sitting beside the scheduler
  always_comb alu_o = alu_ref(alu_a, alu_b, alu_op);

  // Response monitor: compares whatever the DUT presents with the queue front
  always @(negedge clk) begin
    if (!reset_n) begin
      front_seen = 1'b0;
    end else begin
      check("op_count", 32'(op_count), 32'(16'(count_base + 16'(completed))));
      if (exp_q.size() == 0) begin
        check("rsp_valid_idle", 32'(rsp_valid), 32'd0);
      end else begin
        if (!front_seen) begin
          check("rsp_latency", 32'(rsp_valid), 32'(cyc >= exp_q[0].due));
          if (rsp_valid || cyc >= exp_q[0].due) front_seen = 1'b1;
        end else begin
          check("rsp_valid_hold", 32'(rsp_valid), 32'd1);
        end
        if (rsp_valid) begin
          check("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
          check("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            completed++;
            idle_cycle = cyc + 1;
            front_seen = 1'b0;
          end
        end
      end
    end
  end

  // Predict the grant from the round-robin rule and queue the expected response
  task automatic checkOutput();
    bit           idle;
    logic [N-1:0] exp_rdy;
    int           g;
    exp_t         e;
    idle    = (accepted == completed) && (cyc >= idle_cycle);
    exp_rdy = '0;
    g       = -1;
    if (idle) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (model_ptr + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("busy", 32'(busy), 32'(!idle));
    if (g >= 0) begin
      e.id   = IDW'(g);
      e.data = alu_ref(req_a[g*W +: W], req_b[g*W +: W], req_op[g*3 +: 3]);
      e.due  = cyc + 2;
      exp_q.push_back(e);
      accepted++;
      model_ptr = (g + 1) % N;
    end
  endtask

  // Drive one cycle of requests just after the rising edge, then check grants mid-low-phase
  task automatic applyStimulus(input logic [N-1:0] valid, input logic rdy, input bit fixed,
                               input logic [W-1:0] fa, input logic [W-1:0] fb,
                               input logic [2:0] fop);
    @(posedge clk);
    #1;
    req_valid = valid;
    rsp_ready = rdy;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = fixed ? fa : W'($urandom);
      req_b[i*W +: W] = fixed ? fb : W'($urandom);
      req_op[i*3 +: 3] = fixed ? fop : 3'($urandom);
    end
    @(negedge clk);
    #1;
    checkOutput();
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || accepted != completed) && n < bound) begin
      applyStimulus('0, 1'b1, 1'b0, '0, '0, '0);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    applyStimulus('0, 1'b1, 1'b0, '0, '0, '0);
  endtask

  // Assert reset with requests pending and confirm every output clears at once
  task automatic doReset();
    req_valid = '1;
    reset_n   = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    req_valid = '0;
    exp_q.delete();
    accepted   = completed;
    model_ptr  = 0;
    count_base = 16'd0 - 16'(completed);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b0;
    doReset();

    $display("[TB] single request from requester 0");
    applyStimulus(4'b0001, 1'b1, 1'b1, 8'h1f, 8'h11, 3'b001);
    drain(20);
    check("op_count_single", 32'(op_count), 32'd1);

    $display("[TB] all requesters valid, consumer always ready");
    repeat (16) applyStimulus(4'b1111, 1'b1, 1'b0, '0, '0, '0);
    drain(20);

    $display("[TB] response backpressure");
    applyStimulus(4'b1111, 1'b0, 1'b0, '0, '0, '0);
    repeat (7) applyStimulus(4'b1111, 1'b0, 1'b0, '0, '0, '0);
    drain(20);

    $display("[TB] pointer wrap");
    applyStimulus(4'b0010, 1'b1, 1'b0, '0, '0, '0);
    drain(20);
    applyStimulus(4'b0010, 1'b1, 1'b0, '0, '0, '0);
    check("wrap_grant", 32'(req_ready), 32'(4'b0010));
    drain(20);
    applyStimulus(4'b1111, 1'b1, 1'b0, '0, '0, '0);
    check("after_wrap_grant", 32'(req_ready), 32'(4'b0100));
    drain(20);

    $display("[TB] op_count wrap and opcode sweep");
    @(posedge clk);
    #1;
    force dut.op_count = 16'hFFFF;
    count_base = 16'hFFFF - 16'(completed);
    #1;
    release dut.op_count;
    applyStimulus(4'b1000, 1'b1, 1'b0, '0, '0, '0);
    drain(20);
    check("op_count_wrap", 32'(op_count), 32'd0);
    for (int op = 0; op < 8; op++) begin
      applyStimulus(4'(1 << $urandom_range(0, 3)), 1'b1, 1'b1, 8'h91, 8'h91, 3'(op));
      drain(20);
    end

    $display("[TB] reset while holding a response");
    applyStimulus(4'b0100, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) applyStimulus('0, 1'b0, 1'b0, '0, '0, '0);
    doReset();
    applyStimulus(4'b1111, 1'b1, 1'b0, '0, '0, '0);
    check("post_reset_grant", 32'(req_ready), 32'(4'b0001));
    drain(20);

    $display("[TB] random traffic");
    repeat (400) applyStimulus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
                               1'b0, '0, '0, '0);
    drain(60);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
